// File: rtl/uart_rx_buffered_pkg.sv
// Shared definitions for the buffered UART receiver: receiver FSM states,
// default bit timing and frame geometry.
package uart_rx_buffered_pkg;

    // Receiver FSM states, in the order a frame walks through them
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // 100 MHz system clock at 9600 baud
    localparam int DEFAULT_CLKS_PER_BIT = 10416;

    // 8N1 framing: eight data bits, no parity, one stop bit
    localparam int DATA_BITS = 8;

endpackage

// File: rtl/uart_rx_buffered_sync_fifo.sv
// First-word-fall-through synchronous FIFO. The head entry is visible on
// rd_data whenever rd_valid is high; a push into a full FIFO is accepted only
// when a pop frees a slot in the same cycle, otherwise it is dropped and
// flagged on drop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             empty;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // A pop on an empty FIFO is ignored; a full FIFO takes a push only if it also pops
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;

    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of two
    // NOTE: state is updated with <= so every register sees pre-edge values, whatever the statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write port
    // NOTE: the storage array is deliberately not reset; rd_data is forced to zero while empty instead.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_rx_buffered.sv
// 8N1 UART receiver with a small receive FIFO. The rx pin is synchronised,
// frames are sampled at bit centre and completed bytes are queued for a
// valid/ready consumer. Bad stop bits and FIFO overflows are reported as
// single-cycle pulses.
module uart_rx_buffered
    import uart_rx_buffered_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4,
    parameter int CNT_W        = 14
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx,
    output logic [7:0]                    rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          frame_err,
    output logic                          overrun
);

    localparam int          BIT_CNT_W    = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]     HALF_LAST    = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]     BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_CNT_LAST = BIT_CNT_W'(DATA_BITS - 1);

    rx_state_t              state;
    logic                   rx_meta;
    logic                   rx_s;
    logic [CNT_W-1:0]       clk_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   push_byte;
    logic                   fifo_drop;

    // Two-flop synchroniser for the asynchronous rx pin; idles high like the line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // Frame FSM: detect start, confirm it at half a bit, then sample each bit at its centre
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            clk_cnt   <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_cnt <= '0;
                    if (!rx_s) begin
                        state <= START;
                    end
                end
                START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        // A line that is high again mid start bit was a glitch
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == BIT_CNT_LAST) begin
                            state <= STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt   <= '0;
                        frame_err <= !rx_s;
                        // Leave mid stop bit so a following start edge is not missed
                        state     <= IDLE;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte is handed to the FIFO in the stop-bit sample cycle when the stop bit is good
    assign push_byte = (state == STOP) && (clk_cnt == BIT_LAST) && rx_s;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push_byte),
        .wr_data  (shift_reg),
        .pop      (rd_ready),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .count    (fifo_count),
        .drop     (fifo_drop)
    );

    // Registered overrun pulse, one cycle after the dropped byte's stop sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun <= 1'b0;
        end else begin
            overrun <= fifo_drop;
        end
    end

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Self-checking bench for uart_rx_buffered: drives 8N1 frames on rx, consumes
// bytes through the valid/ready port and compares against a queue model.
module tb_uart_rx_buffered;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rd_ready = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [2:0] fifo_count;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;

    // consumer / observer state
    int         cons_mode = 0;   // 0: bench drives rd_ready, 1: always ready, 2: random ready
    logic [7:0] got[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;

    uart_rx_buffered #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .CNT_W        (14)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .fifo_count (fifo_count),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // Observe pulses and (in consumer modes) pick rd_ready and record the accepted byte
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1)   ov_cnt++;
        if (cons_mode == 1) rd_ready = 1'b1;
        else if (cons_mode == 2) rd_ready = 1'($urandom_range(0, 1));
        if (cons_mode != 0 && rd_valid === 1'b1 && rd_ready) got.push_back(rd_data);
    end

    // ---------------------------------------------------------------- helpers
    task automatic start_test(input int mode);
        @(posedge clk);
        #1;
        cons_mode = mode;
        rd_ready  = 1'b0;
        got.delete();
        fe_cnt = 0;
        ov_cnt = 0;
        @(negedge clk);
    endtask

    task automatic set_mode(input int mode);
        @(posedge clk);
        #1;
        cons_mode = mode;
        rd_ready  = 1'b0;
        @(negedge clk);
    endtask

    // Drives the first nbits of a frame (LSB first); must be entered at a negedge
    task automatic drive_bits(input logic [9:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            rx = frame[i];
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        drive_bits({stop_bit, b, 1'b0}, 10);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_got(input int n, input string name);
        int k = 0;
        while (got.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (got.size() < n) begin
            bad++;
            $display("FAIL %s timeout: got %0d bytes, wanted %0d", name, got.size(), n);
        end
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++;
        if ({rd_valid, fifo_count, frame_err, overrun, rd_data} !== 14'h0) begin
            bad++;
            $display("FAIL reset_hold: valid=%b count=%0d fe=%b ov=%b data=%h, want all 0",
                     rd_valid, fifo_count, frame_err, overrun, rd_data);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if ({rd_valid, fifo_count, frame_err, overrun, rd_data} !== 14'h0) begin
            bad++;
            $display("FAIL reset_release: valid=%b count=%0d fe=%b ov=%b data=%h, want all 0",
                     rd_valid, fifo_count, frame_err, overrun, rd_data);
        end
    endtask

    task automatic test_in_order();
        logic [7:0] exp_q[$] = '{8'hAB, 8'hFF, 8'h00, 8'h12};
        start_test(1);
        foreach (exp_q[i]) send_byte(exp_q[i], 1'b1);   // back to back, no idle gap
        wait_got(4, "in_order_drain");
        idle(20);
        foreach (exp_q[i]) begin
            total++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                bad++;
                $display("FAIL in_order_byte%0d: got %h, want %h", i,
                         (i < got.size()) ? got[i] : 8'hxx, exp_q[i]);
            end
        end
        total++;
        if (fe_cnt != 0 || ov_cnt != 0 || got.size() != 4) begin
            bad++;
            $display("FAIL in_order_pulses: fe=%0d ov=%0d bytes=%0d, want 0 0 4",
                     fe_cnt, ov_cnt, got.size());
        end
    endtask

    task automatic test_overrun();
        logic [7:0] sent[$] = '{8'hAB, 8'hFF, 8'h00, 8'h12, 8'h55};
        logic [7:0] model_q[$];
        int         exp_ov = 0;
        start_test(0);
        foreach (sent[i]) begin
            send_byte(sent[i], 1'b1);
            if (model_q.size() < DEPTH) model_q.push_back(sent[i]);
            else exp_ov++;
        end
        idle(4);
        total++;
        if (fifo_count !== 3'(DEPTH) || ov_cnt != exp_ov) begin
            bad++;
            $display("FAIL overrun_full: count=%0d ov=%0d, want %0d %0d",
                     fifo_count, ov_cnt, DEPTH, exp_ov);
        end
        set_mode(1);
        wait_got(model_q.size(), "overrun_drain");
        idle(5);
        foreach (model_q[i]) begin
            total++;
            if (i >= got.size() || got[i] !== model_q[i]) begin
                bad++;
                $display("FAIL overrun_byte%0d: got %h, want %h", i,
                         (i < got.size()) ? got[i] : 8'hxx, model_q[i]);
            end
        end
        total++;
        if (fifo_count !== 3'd0 || got.size() != model_q.size() || fe_cnt != 0) begin
            bad++;
            $display("FAIL overrun_after: count=%0d bytes=%0d fe=%0d, want 0 %0d 0",
                     fifo_count, got.size(), fe_cnt, model_q.size());
        end
    endtask

    task automatic test_frame_err();
        start_test(1);
        send_byte(8'hA5, 1'b0);
        idle(2 * CPB);
        total++;
        if (fe_cnt != 1 || got.size() != 0 || ov_cnt != 0) begin
            bad++;
            $display("FAIL frame_err_bad: fe=%0d bytes=%0d ov=%0d, want 1 0 0",
                     fe_cnt, got.size(), ov_cnt);
        end
        send_byte(8'h3C, 1'b1);
        wait_got(1, "frame_err_next");
        idle(5);
        total++;
        if (got.size() != 1 || got[0] !== 8'h3C || fe_cnt != 1) begin
            bad++;
            $display("FAIL frame_err_next: bytes=%0d first=%h fe=%0d, want 1 3c 1",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx, fe_cnt);
        end
    endtask

    task automatic test_glitch();
        start_test(1);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(3 * CPB);
        total++;
        if (got.size() != 0 || fe_cnt != 0 || ov_cnt != 0 || fifo_count !== 3'd0) begin
            bad++;
            $display("FAIL glitch: bytes=%0d fe=%0d ov=%0d count=%0d, want 0 0 0 0",
                     got.size(), fe_cnt, ov_cnt, fifo_count);
        end
        send_byte(8'h5A, 1'b1);
        wait_got(1, "glitch_recover");
        total++;
        if (got.size() < 1 || got[0] !== 8'h5A) begin
            bad++;
            $display("FAIL glitch_recover: got %h, want 5a", (got.size() > 0) ? got[0] : 8'hxx);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] fill[$];
        logic [7:0] last;
        logic [7:0] popped;
        logic [7:0] model_q[$];
        start_test(0);
        for (int i = 0; i < DEPTH; i++) fill.push_back(8'($urandom));
        last = 8'($urandom);
        foreach (fill[i]) send_byte(fill[i], 1'b1);
        total++;
        if (fifo_count !== 3'(DEPTH)) begin
            bad++;
            $display("FAIL full_pop_fill: count=%0d, want %0d", fifo_count, DEPTH);
        end
        // fifth frame: pop lands on the stop-bit sample edge, 10 clocks into the stop bit
        drive_bits({1'b1, last, 1'b0}, 9);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        popped   = rd_data;
        rd_ready = 1'b1;
        @(negedge clk);
        rd_ready = 1'b0;
        repeat (5) @(negedge clk);
        model_q = fill;
        void'(model_q.pop_front());
        model_q.push_back(last);
        total++;
        if (popped !== fill[0] || fifo_count !== 3'(DEPTH) || ov_cnt != 0) begin
            bad++;
            $display("FAIL full_pop_same_cycle: popped=%h count=%0d ov=%0d, want %h %0d 0",
                     popped, fifo_count, ov_cnt, fill[0], DEPTH);
        end
        set_mode(1);
        wait_got(DEPTH, "full_pop_drain");
        foreach (model_q[i]) begin
            total++;
            if (i >= got.size() || got[i] !== model_q[i]) begin
                bad++;
                $display("FAIL full_pop_byte%0d: got %h, want %h", i,
                         (i < got.size()) ? got[i] : 8'hxx, model_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        start_test(0);
        send_byte(8'h42, 1'b1);          // leaves one byte queued, cleared by the reset
        drive_bits({1'b1, 8'h77, 1'b0}, 5);
        rst_n = 1'b0;
        rx    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if ({rd_valid, fifo_count, frame_err, overrun, rd_data} !== 14'h0) begin
                bad++;
                $display("FAIL reset_mid_hold%0d: valid=%b count=%0d fe=%b ov=%b data=%h, want all 0",
                         i, rd_valid, fifo_count, frame_err, overrun, rd_data);
            end
        end
        rst_n = 1'b1;
        idle(10);
        set_mode(1);
        send_byte(8'h81, 1'b1);
        wait_got(1, "reset_mid_next");
        idle(2 * CPB);
        total++;
        if (got.size() != 1 || got[0] !== 8'h81 || fe_cnt != 0 || ov_cnt != 0) begin
            bad++;
            $display("FAIL reset_mid_next: bytes=%0d first=%h fe=%0d ov=%0d, want 1 81 0 0",
                     got.size(), (got.size() > 0) ? got[0] : 8'hxx, fe_cnt, ov_cnt);
        end
    endtask

    task automatic test_random();
        logic [7:0] model_q[$];
        int         exp_fe = 0;
        start_test(2);
        for (int n = 0; n < 16; n++) begin
            logic [7:0] b       = 8'($urandom);
            logic       good    = ($urandom_range(0, 5) != 0);
            int         gap     = good ? $urandom_range(0, 20) : CPB + $urandom_range(0, 8);
            send_byte(b, good);
            if (good) model_q.push_back(b);
            else exp_fe++;
            if (gap > 0) idle(gap);
        end
        wait_got(model_q.size(), "random_drain");
        idle(10);
        foreach (model_q[i]) begin
            total++;
            if (i >= got.size() || got[i] !== model_q[i]) begin
                bad++;
                $display("FAIL random_byte%0d: got %h, want %h", i,
                         (i < got.size()) ? got[i] : 8'hxx, model_q[i]);
            end
        end
        total++;
        if (fe_cnt != exp_fe || ov_cnt != 0 || got.size() != model_q.size()) begin
            bad++;
            $display("FAIL random_counts: fe=%0d ov=%0d bytes=%0d, want %0d 0 %0d",
                     fe_cnt, ov_cnt, got.size(), exp_fe, model_q.size());
        end
        set_mode(0);
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
